// File: rtl/timer_count_core.sv
`default_nettype none
// ============================================================================
// Module   : timer_count_core
// Purpose  : Prescaled down-counting timer with a small register file.
//            Registers: 0 CTRL (EN, AUTO_RELOAD, IRQ_EN, PRESCALE[8+:PW]),
//            1 LOAD, 2 COUNT, 3 STATUS (EXPIRED w1c, RUNNING = EN).
//            Each prescaler tick decrements COUNT; a tick at COUNT=0 is an
//            expiry that reloads (auto-reload) or stops the timer (one-shot).
// Ports    : ACLK          - clock, rising edge
//            ARESET        - asynchronous active-high reset
//            cfg_wr_en/addr/data - single-cycle register write
//            cfg_rd_en/addr      - single-cycle register read request
//            cfg_rd_data/valid   - registered read response (1 cycle later)
//            irq           - level interrupt, EXPIRED & IRQ_EN (registered)
//            expire_pulse  - one-cycle pulse per expiry event
// Revision : 1.0 - initial release
// ============================================================================
module timer_count_core #(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_wr_en,
    input  logic [1:0]            cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wr_data,
    input  logic                  cfg_rd_en,
    input  logic [1:0]            cfg_rd_addr,
    output logic [DATA_WIDTH-1:0] cfg_rd_data,
    output logic                  cfg_rd_valid,
    output logic                  irq,
    output logic                  expire_pulse
);

    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_load   = 2'd1;
    localparam logic [1:0] c_addr_count  = 2'd2;
    localparam logic [1:0] c_addr_status = 2'd3;

    localparam logic [DATA_WIDTH-1:0]     c_count_one = 1;
    localparam logic [PRESCALE_WIDTH-1:0] c_presc_one = 1;

    // Register state
    logic                      r_en;
    logic                      r_auto_reload;
    logic                      r_irq_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [DATA_WIDTH-1:0]     r_load;
    logic [DATA_WIDTH-1:0]     r_count;
    logic [PRESCALE_WIDTH-1:0] r_presc_cnt;
    logic                      r_expired;
    logic                      r_irq;
    logic                      r_expire_pulse;
    logic [DATA_WIDTH-1:0]     r_rd_data;
    logic                      r_rd_valid;

    // Decoded strobes and timer events
    logic                  w_ctrl_wr;
    logic                  w_load_wr;
    logic                  w_count_wr;
    logic                  w_status_wr;
    logic                  w_tick;
    logic                  w_suppress;
    logic                  w_expire;
    logic [DATA_WIDTH-1:0] w_ctrl_val;
    logic [DATA_WIDTH-1:0] w_status_val;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_ctrl_wr   = cfg_wr_en && (cfg_wr_addr == c_addr_ctrl);
    assign w_load_wr   = cfg_wr_en && (cfg_wr_addr == c_addr_load);
    assign w_count_wr  = cfg_wr_en && (cfg_wr_addr == c_addr_count);
    assign w_status_wr = cfg_wr_en && (cfg_wr_addr == c_addr_status);

    assign w_tick = r_en && (r_presc_cnt == r_prescale);

    // A tick has no effect on COUNT/EXPIRED when software is rewriting the
    // counter value or stopping the timer in the same cycle.
    assign w_suppress = w_load_wr || w_count_wr || (w_ctrl_wr && !cfg_wr_data[0]);
    assign w_expire   = w_tick && !w_suppress && (r_count == '0);

    always_comb begin
        w_ctrl_val                    = '0;
        w_ctrl_val[0]                 = r_en;
        w_ctrl_val[1]                 = r_auto_reload;
        w_ctrl_val[2]                 = r_irq_en;
        w_ctrl_val[8 +: PRESCALE_WIDTH] = r_prescale;

        w_status_val    = '0;
        w_status_val[0] = r_expired;
        w_status_val[1] = r_en;

        case (cfg_rd_addr)
            c_addr_ctrl:  w_rd_mux = w_ctrl_val;
            c_addr_load:  w_rd_mux = r_load;
            c_addr_count: w_rd_mux = r_count;
            default:      w_rd_mux = w_status_val;
        endcase
    end

    // CTRL register; a one-shot expiry drops EN unless software writes CTRL
    // in that same cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_en          <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_prescale    <= '0;
        end else if (w_ctrl_wr) begin
            r_en          <= cfg_wr_data[0];
            r_auto_reload <= cfg_wr_data[1];
            r_irq_en      <= cfg_wr_data[2];
            r_prescale    <= cfg_wr_data[8 +: PRESCALE_WIDTH];
        end else if (w_expire && !r_auto_reload) begin
            r_en <= 1'b0;
        end
    end

    // Prescaler: restarts from zero on enable, frozen while disabled.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_presc_cnt <= '0;
        end else if (w_ctrl_wr && !r_en && cfg_wr_data[0]) begin
            r_presc_cnt <= '0;
        end else if (r_en) begin
            r_presc_cnt <= w_tick ? '0 : (r_presc_cnt + c_presc_one);
        end
    end

    // LOAD and COUNT
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_load  <= '0;
            r_count <= '0;
        end else begin
            if (w_load_wr) begin
                r_load <= cfg_wr_data;
            end
            if (w_count_wr) begin
                r_count <= cfg_wr_data;
            end else if (w_load_wr) begin
                if (!r_en) begin
                    r_count <= cfg_wr_data;
                end
            end else if (w_tick && !w_suppress) begin
                if (r_count == '0) begin
                    if (r_auto_reload) begin
                        r_count <= r_load;
                    end
                end else begin
                    r_count <= r_count - c_count_one;
                end
            end
        end
    end

    // EXPIRED (set wins over a same-cycle clear), irq and pulse
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_expired      <= 1'b0;
            r_irq          <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (w_status_wr && cfg_wr_data[0]) begin
                r_expired <= 1'b0;
            end
            r_irq          <= r_expired && r_irq_en;
            r_expire_pulse <= w_expire;
        end
    end

    // Read response samples pre-write register values
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= cfg_rd_en;
            r_rd_data  <= cfg_rd_en ? w_rd_mux : '0;
        end
    end

    assign cfg_rd_data  = r_rd_data;
    assign cfg_rd_valid = r_rd_valid;
    assign irq          = r_irq;
    assign expire_pulse = r_expire_pulse;

endmodule
`default_nettype wire

// File: tb/tb_timer_count_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_count_core
// Purpose  : Self-checking bench for timer_count_core: directed scenarios for
//            the register map, timing races and reset, then a random run
//            against a cycle-level behavioural model of the timer rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_count_core;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        cfg_rd_en;
    logic [1:0]  cfg_rd_addr;
    logic [31:0] cfg_rd_data;
    logic        cfg_rd_valid;
    logic        irq;
    logic        expire_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    timer_count_core #(.DATA_WIDTH(32), .PRESCALE_WIDTH(8)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_rd_en    (cfg_rd_en),
        .cfg_rd_addr  (cfg_rd_addr),
        .cfg_rd_data  (cfg_rd_data),
        .cfg_rd_valid (cfg_rd_valid),
        .irq          (irq),
        .expire_pulse (expire_pulse)
    );

    always #5 ACLK = ~ACLK;

    // Advance n cycles; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        step(1);
        cfg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic v, output logic [31:0] d);
        cfg_rd_en = 1'b1; cfg_rd_addr = a;
        step(1);
        cfg_rd_en = 1'b0;
        v = cfg_rd_valid;
        d = cfg_rd_data;
    endtask

    task automatic do_reset;
        ARESET = 1'b1;
        step(2);
        ARESET = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        logic v; logic [31:0] d;
        ARESET = 1'b1;
        step(2);
        n_checks++;
        if ({cfg_rd_data, cfg_rd_valid, irq, expire_pulse} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd_data=%h valid=%b irq=%b pulse=%b, want all 0",
                     cfg_rd_data, cfg_rd_valid, irq, expire_pulse);
        end
        ARESET = 1'b0;
        step(1);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v, d);
            n_checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got valid=%b data=%h, want 1/00000000", a, v, d);
            end
        end
    endtask

    task automatic test_auto_reload;
        logic v; logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h7);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            n_checks++;
            if (expire_pulse !== (k % 4 == 0)) begin
                n_fail++;
                $display("FAIL auto_pulse k=%0d: got %b, want %b", k, expire_pulse, (k % 4 == 0));
            end
            n_checks++;
            if (irq !== (k >= 5)) begin
                n_fail++;
                $display("FAIL auto_irq k=%0d: got %b, want %b", k, irq, (k >= 5));
            end
        end
        rd(2'd3, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h3) begin
            n_fail++;
            $display("FAIL auto_status: got valid=%b data=%h, want 1/00000003", v, d);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_prescale_oneshot;
        logic v; logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h0201);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            n_checks++;
            if (expire_pulse !== (k == 9)) begin
                n_fail++;
                $display("FAIL oneshot_pulse k=%0d: got %b, want %b", k, expire_pulse, (k == 9));
            end
        end
        rd(2'd3, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h1) begin
            n_fail++;
            $display("FAIL oneshot_status: got %h, want 00000001", d);
        end
        rd(2'd2, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL oneshot_count: got %h, want 00000000", d);
        end
        rd(2'd0, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h0200 || expire_pulse !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_ctrl: got ctrl=%h pulse=%b irq=%b, want 00000200/0/0",
                     d, expire_pulse, irq);
        end
    endtask

    task automatic test_w1c_race;
        logic v; logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h7);
        step(3);
        wr(2'd3, 32'h1);             // lands on the expiry edge
        n_checks++;
        if (expire_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_pulse: got %b, want 1", expire_pulse);
        end
        // clear one cycle later, with a same-cycle STATUS read
        cfg_wr_en = 1'b1; cfg_wr_addr = 2'd3; cfg_wr_data = 32'h1;
        cfg_rd_en = 1'b1; cfg_rd_addr = 2'd3;
        step(1);
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
        n_checks++;
        if (cfg_rd_valid !== 1'b1 || cfg_rd_data !== 32'h3) begin
            n_fail++;
            $display("FAIL w1c_kept: got valid=%b data=%h, want 1/00000003", cfg_rd_valid, cfg_rd_data);
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_irq_high: got %b, want 1", irq);
        end
        step(1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq_drop: got %b, want 0", irq);
        end
        rd(2'd3, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h2) begin
            n_fail++;
            $display("FAIL w1c_cleared: got %h, want 00000002", d);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_write_tick_race;
        logic v; logic [31:0] d;
        do_reset();
        wr(2'd1, 32'h20);
        wr(2'd0, 32'h0301);
        step(3);
        wr(2'd2, 32'h10);            // COUNT write on a tick edge
        rd(2'd2, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h10) begin
            n_fail++;
            $display("FAIL race_count_wr: got %h, want 00000010", d);
        end
        step(2);
        wr(2'd0, 32'h0300);          // disable on a tick edge
        rd(2'd2, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h10) begin
            n_fail++;
            $display("FAIL race_disable: got %h, want 00000010", d);
        end
        wr(2'd0, 32'h0301);
        step(3);
        wr(2'd1, 32'h55);            // LOAD write on a tick edge while running
        rd(2'd2, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h10) begin
            n_fail++;
            $display("FAIL race_load_wr_count: got %h, want 00000010", d);
        end
        rd(2'd1, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h55) begin
            n_fail++;
            $display("FAIL race_load_wr_load: got %h, want 00000055", d);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_read_timing;
        logic [31:0] d0;
        logic [31:0] exp_v [4];
        do_reset();
        d0 = $urandom;
        wr(2'd0, 32'hFFFF_05FC);     // unused bits set, EN stays 0
        wr(2'd1, d0);
        exp_v = '{32'h0000_0504, d0, d0, 32'h0};
        cfg_rd_en = 1'b1;
        for (int a = 0; a < 4; a++) begin
            cfg_rd_addr = a[1:0];
            step(1);
            n_checks++;
            if (cfg_rd_valid !== 1'b1 || cfg_rd_data !== exp_v[a]) begin
                n_fail++;
                $display("FAIL b2b_read%0d: got valid=%b data=%h, want 1/%h",
                         a, cfg_rd_valid, cfg_rd_data, exp_v[a]);
            end
        end
        cfg_rd_en = 1'b0;
        step(1);
        n_checks++;
        if (cfg_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_valid_end: got %b, want 0", cfg_rd_valid);
        end
    endtask

    task automatic test_reset_mid_count;
        logic v; logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h5);
        step(5);                      // COUNT is now 5
        cfg_rd_en = 1'b1; cfg_rd_addr = 2'd2;
        #2 ARESET = 1'b1;
        #1;
        n_checks++;
        if ({cfg_rd_data, cfg_rd_valid, irq, expire_pulse} !== 35'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got rd_data=%h valid=%b irq=%b pulse=%b, want all 0",
                     cfg_rd_data, cfg_rd_valid, irq, expire_pulse);
        end
        cfg_rd_en = 1'b0;
        step(1);
        ARESET = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            n_checks++;
            if (expire_pulse !== 1'b0 || irq !== 1'b0 || cfg_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_quiet k=%0d: got pulse=%b irq=%b valid=%b, want 0/0/0",
                         k, expire_pulse, irq, cfg_rd_valid);
            end
        end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v, d);
            n_checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                n_fail++;
                $display("FAIL midreset_reg%0d: got %h, want 00000000", a, d);
            end
        end
    endtask

    // Behavioural model state for the random run
    logic        m_en, m_ar, m_ie, m_exp, m_irq, m_pulse, m_rdv;
    logic [7:0]  m_ps, m_presc;
    logic [31:0] m_load, m_count, m_rdd;

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {16'h0, m_ps, 5'h0, m_ie, m_ar, m_en};
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {30'h0, m_en, m_exp};
        endcase
    endfunction

    task automatic test_random;
        logic        we, re, tick, blocked, expire;
        logic [1:0]  wa, ra;
        logic [31:0] wd;
        logic        n_en, n_ar, n_ie, n_exp;
        logic [7:0]  n_ps, n_presc;
        logic [31:0] n_load, n_count;
        do_reset();
        {m_en, m_ar, m_ie, m_exp, m_irq, m_pulse, m_rdv} = '0;
        {m_ps, m_presc, m_load, m_count, m_rdd} = '0;
        for (int c = 0; c < 3000; c++) begin
            we = ($urandom_range(0, 7) == 0);
            wa = 2'($urandom_range(0, 3));
            re = $urandom_range(0, 1) == 1;
            ra = 2'($urandom_range(0, 3));
            case (wa)
                2'd0: begin
                    wd = $urandom;
                    wd[15:8] = 8'($urandom_range(0, 3));
                    wd[0] = ($urandom_range(0, 3) != 0);
                end
                2'd1, 2'd2: wd = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default: wd = $urandom;
            endcase
            cfg_wr_en = we; cfg_wr_addr = wa; cfg_wr_data = wd;
            cfg_rd_en = re; cfg_rd_addr = ra;

            // Timer rules for this cycle
            tick    = m_en && (m_presc == m_ps);
            blocked = we && (wa == 2'd1 || wa == 2'd2 || (wa == 2'd0 && !wd[0]));
            expire  = tick && !blocked && (m_count == 0);
            {n_en, n_ar, n_ie, n_ps} = {m_en, m_ar, m_ie, m_ps};
            n_load = m_load; n_count = m_count; n_presc = m_presc; n_exp = m_exp;
            if (m_en) n_presc = tick ? 8'd0 : m_presc + 8'd1;
            if (tick && !blocked) begin
                if (m_count != 0)  n_count = m_count - 1;
                else if (m_ar)     n_count = m_load;
                else               n_en = 1'b0;
            end
            if (expire) n_exp = 1'b1;
            else if (we && wa == 2'd3 && wd[0]) n_exp = 1'b0;
            if (we && wa == 2'd0) begin
                {n_en, n_ar, n_ie, n_ps} = {wd[0], wd[1], wd[2], wd[15:8]};
                if (!m_en && wd[0]) n_presc = 8'd0;
            end
            if (we && wa == 2'd1) begin
                n_load = wd;
                if (!m_en) n_count = wd;
            end
            if (we && wa == 2'd2) n_count = wd;
            m_irq   = m_exp && m_ie;
            m_pulse = expire;
            m_rdv   = re;
            m_rdd   = m_reg(ra);
            {m_en, m_ar, m_ie, m_ps, m_presc, m_exp} = {n_en, n_ar, n_ie, n_ps, n_presc, n_exp};
            m_load  = n_load;
            m_count = n_count;

            step(1);
            n_checks++;
            if (expire_pulse !== m_pulse) begin
                n_fail++;
                $display("FAIL rand_pulse c=%0d: got %b, want %b", c, expire_pulse, m_pulse);
            end
            n_checks++;
            if (irq !== m_irq) begin
                n_fail++;
                $display("FAIL rand_irq c=%0d: got %b, want %b", c, irq, m_irq);
            end
            n_checks++;
            if (cfg_rd_valid !== m_rdv) begin
                n_fail++;
                $display("FAIL rand_rd_valid c=%0d: got %b, want %b", c, cfg_rd_valid, m_rdv);
            end
            if (m_rdv) begin
                n_checks++;
                if (cfg_rd_data !== m_rdd) begin
                    n_fail++;
                    $display("FAIL rand_rd_data c=%0d addr=%0d: got %h, want %h", c, ra, cfg_rd_data, m_rdd);
                end
            end
        end
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESET = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_addr = 2'd0; cfg_wr_data = 32'h0;
        cfg_rd_en = 1'b0; cfg_rd_addr = 2'd0;
        #1;
        test_reset();
        test_auto_reload();
        test_prescale_oneshot();
        test_w1c_race();
        test_write_tick_race();
        test_read_timing();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_count_core.md
TIMER_COUNT_CORE -- requirements
Module: timer_count_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register and bus width (only 32 is supported).
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 8, the width of the prescaler field and counter.
REQ-003 SHALL have port ACLK, input, 1, the only clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cfg_wr_en, input, 1, one-cycle write strobe from the AXI4-Lite register stage.
REQ-006 SHALL have port cfg_wr_addr, input, 2, register index for the write.
REQ-007 SHALL have port cfg_wr_data, input, DATA_WIDTH, write data.
REQ-008 SHALL have port cfg_rd_en, input, 1, one-cycle read strobe.
REQ-009 SHALL have port cfg_rd_addr, input, 2, register index for the read.
REQ-010 SHALL have port cfg_rd_data, output, DATA_WIDTH, read data.
REQ-011 SHALL have port cfg_rd_valid, output, 1, qualifies cfg_rd_data for one cycle.
REQ-012 SHALL have port irq, output, 1, level interrupt.
REQ-013 SHALL have port expire_pulse, output, 1, one-cycle pulse on each expiry event.

Function
REQ-014 SHALL implement the register map: 0 CTRL (bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[8+PRESCALE_WIDTH-1:8] PRESCALE); 1 LOAD; 2 COUNT; 3 STATUS (bit0 EXPIRED, bit1 RUNNING).
REQ-015 SHALL read unused bits as 0 and ignore writes to unused bits.
REQ-016 SHALL return read data registered, with cfg_rd_valid high exactly in the cycle after cfg_rd_en, and the value sampled at the cfg_rd_en edge.
REQ-017 SHALL accept back-to-back reads, one per cycle.
REQ-018 SHALL apply a write at the clock edge where cfg_wr_en is high.
REQ-019 SHALL, on a LOAD write, update LOAD, and also copy the written value into COUNT when EN is 0.
REQ-020 SHALL, on a COUNT write, set COUNT directly.
REQ-021 SHALL, on a STATUS write, clear EXPIRED when bit0 is 1; RUNNING is read-only and equals EN.
REQ-022 SHALL clear the prescaler counter to 0 on any CTRL write that takes EN from 0 to 1.
REQ-023 SHALL, while EN=1, increment the prescaler each cycle and generate an internal tick when it equals PRESCALE, then wrap it to 0.
REQ-024 SHALL, on a tick with COUNT>0, decrement COUNT by 1.
REQ-025 SHALL, on a tick with COUNT=0, declare an expiry: set EXPIRED, pulse expire_pulse in the next cycle, then either reload COUNT from LOAD (AUTO_RELOAD=1) or clear EN and leave COUNT at 0 (one-shot).
REQ-026 SHALL give an expiry period of (LOAD+1)*(PRESCALE+1) cycles in auto-reload mode.
REQ-027 SHALL hold the prescaler and COUNT frozen while EN=0.
REQ-028 SHALL drive irq registered, as EXPIRED AND IRQ_EN, one cycle after either term changes.
REQ-029 SHALL, when a STATUS clear and an expiry occur in the same cycle, leave EXPIRED set.
REQ-030 SHALL, when a COUNT or LOAD write coincides with a tick, let the write value win and suppress that tick's decrement and expiry; the prescaler continues unaffected.
REQ-031 SHALL, when a CTRL write clearing EN coincides with a tick, suppress the tick.
REQ-032 SHALL, when a read and a write target the same register in the same cycle, return the pre-write value.

Reset
REQ-033 SHALL, while ARESET=1, asynchronously force CTRL, LOAD, COUNT, the prescaler and EXPIRED to 0, and cfg_rd_data, cfg_rd_valid, irq and expire_pulse to 0.
REQ-034 SHALL, on an ARESET assertion mid-count or mid-read, discard in-flight state with no pulse on release.
REQ-035 SHALL start counting only after a CTRL write with EN=1 following reset release.

Verification
REQ-036 SHALL check auto-reload: LOAD=3, CTRL=0x07 (PRESCALE=0) -> expire_pulse every 4 cycles, irq high 1 cycle after the first expiry, STATUS reads 0x3.
REQ-037 SHALL check prescale one-shot: LOAD=2, CTRL=0x0201 -> single expiry 9 cycles after the enable, then EN=0, STATUS=0x1, COUNT=0, no further pulses.
REQ-038 SHALL check the W1C race: STATUS write 0x1 in the expiry cycle -> EXPIRED stays 1; a write one cycle later -> EXPIRED=0 and irq drops the next cycle.
REQ-039 SHALL check the write-vs-tick race: a COUNT=0x10 write on a tick cycle -> COUNT reads 0x10, not 0x0F.
REQ-040 SHALL check read timing: back-to-back reads of regs 0..3 -> four consecutive cfg_rd_valid cycles with the correct data.
REQ-041 SHALL check reset mid-count: ARESET pulsed while COUNT=5 with EN=1 -> all registers read 0, irq=0, and no expire_pulse for 20 cycles.
